// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the FFT datapath: twiddle mode
// encoding, the rounding constant and signed saturation.
package fft_pkg;

    typedef enum logic {
        TW_MULT       = 1'b0,
        TW_ONE_BYPASS = 1'b1
    } tw_mode_e;

    // Half an LSB of the Q1.(tw_width-1) product, added before truncation.
    function automatic logic [63:0] rnd_const(input int tw_width);
        rnd_const = 64'd1 << (tw_width - 32'sd2);
    endfunction

    function automatic logic signed [31:0] sat_hi(input int width);
        sat_hi = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_lo(input int width);
        sat_lo = -sat_hi(width) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_val(input logic signed [31:0] x,
                                                   input int width);
        if (x > sat_hi(width)) begin
            sat_val = sat_hi(width);
        end else if (x < sat_lo(width)) begin
            sat_val = sat_lo(width);
        end else begin
            sat_val = x;
        end
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] x, input int width);
        sat_hit = (x > sat_hi(width)) || (x < sat_lo(width));
    endfunction

endpackage

// File: rtl/cmul_round.sv
// One-stage complex multiply b*w with round-half-up to WIDTH+1 bits, or a
// straight sign-extended pass of b when the twiddle is exactly 1+0j.
module cmul_round
    import fft_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       en,
    input  logic signed [WIDTH-1:0]    b_re,
    input  logic signed [WIDTH-1:0]    b_im,
    input  logic signed [TW_WIDTH-1:0] w_re,
    input  logic signed [TW_WIDTH-1:0] w_im,
    input  tw_mode_e                   mode,
    output logic signed [WIDTH:0]      p_re,
    output logic signed [WIDTH:0]      p_im
);

    localparam int PW = WIDTH + TW_WIDTH + 1;
    localparam int SH = TW_WIDTH - 1;
    localparam logic signed [PW-1:0] RND = PW'(rnd_const(TW_WIDTH));

    logic signed [PW-1:0] rr_s;
    logic signed [PW-1:0] ii_s;
    logic signed [PW-1:0] ri_s;
    logic signed [PW-1:0] ir_s;
    logic signed [PW-1:0] full_re_s;
    logic signed [PW-1:0] full_im_s;
    logic signed [WIDTH:0] p_re_d;
    logic signed [WIDTH:0] p_re_q;
    logic signed [WIDTH:0] p_im_d;
    logic signed [WIDTH:0] p_im_q;

    // Full-width products; the extra bit keeps the (-1)*(-1) cross sums exact.
    always_comb begin
        rr_s      = PW'(b_re) * PW'(w_re);
        ii_s      = PW'(b_im) * PW'(w_im);
        ri_s      = PW'(b_re) * PW'(w_im);
        ir_s      = PW'(b_im) * PW'(w_re);
        full_re_s = rr_s - ii_s + RND;
        full_im_s = ri_s + ir_s + RND;
    end

    // Product register loads only when the surrounding pipeline advances.
    always_comb begin
        p_re_d = p_re_q;
        p_im_d = p_im_q;
        if (en) begin
            if (mode == TW_ONE_BYPASS) begin
                p_re_d = {b_re[WIDTH-1], b_re};
                p_im_d = {b_im[WIDTH-1], b_im};
            end else begin
                p_re_d = (WIDTH+1)'(full_re_s >>> SH);
                p_im_d = (WIDTH+1)'(full_im_s >>> SH);
            end
        end else begin
            p_re_d = p_re_q;
            p_im_d = p_im_q;
        end
    end

    // Datapath register without reset.
    always_ff @(posedge clock) begin
        p_re_q <= p_re_d;
        p_im_q <= p_im_d;
    end

    assign p_re = p_re_q;
    assign p_im = p_im_q;

endmodule

// File: rtl/butterfly_r2_tw.sv
// Radix-2 DIT butterfly c = a + b*w, d = a - b*w as a 3-stage pipeline that
// stalls as a whole under output backpressure, with optional /2 and saturation.
module butterfly_r2_tw
    import fft_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    a_re,
    input  logic signed [WIDTH-1:0]    a_im,
    input  logic signed [WIDTH-1:0]    b_re,
    input  logic signed [WIDTH-1:0]    b_im,
    input  logic signed [TW_WIDTH-1:0] w_re,
    input  logic signed [TW_WIDTH-1:0] w_im,
    input  logic                       tw_bypass,
    input  logic                       scale,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    c_re,
    output logic signed [WIDTH-1:0]    c_im,
    output logic signed [WIDTH-1:0]    d_re,
    output logic signed [WIDTH-1:0]    d_im,
    output logic                       ovf
);

    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] HALF_UP = SW'(32'sd1);

    logic adv_s;
    logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;

    logic signed [WIDTH-1:0]    a1_re_d, a1_re_q, a1_im_d, a1_im_q;
    logic signed [WIDTH-1:0]    b1_re_d, b1_re_q, b1_im_d, b1_im_q;
    logic signed [TW_WIDTH-1:0] w1_re_d, w1_re_q, w1_im_d, w1_im_q;
    tw_mode_e                   mode1_d, mode1_q;
    logic                       sc1_d, sc1_q;

    logic signed [WIDTH-1:0]    a2_re_d, a2_re_q, a2_im_d, a2_im_q;
    logic                       sc2_d, sc2_q;
    logic signed [WIDTH:0]      p_re_s, p_im_s;

    logic signed [SW-1:0]       sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic signed [SW-1:0]       s_re_s, s_im_s, t_re_s, t_im_s;
    logic signed [WIDTH-1:0]    c_re_d, c_re_q, c_im_d, c_im_q;
    logic signed [WIDTH-1:0]    d_re_d, d_re_q, d_im_d, d_im_q;
    logic                       ovf_d, ovf_q;

    assign adv_s    = ~v3_q | out_ready;
    assign in_ready = adv_s;

    // Valid bits travel with their data; bubbles shift like samples.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (adv_s) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
        end else begin
            v1_d = v1_q;
            v2_d = v2_q;
            v3_d = v3_q;
        end
    end

    // Valid register, cleared asynchronously so in-flight samples are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    // S1 and S2 operand capture, held while the pipe is stalled.
    always_comb begin
        a1_re_d = a1_re_q;  a1_im_d = a1_im_q;
        b1_re_d = b1_re_q;  b1_im_d = b1_im_q;
        w1_re_d = w1_re_q;  w1_im_d = w1_im_q;
        mode1_d = mode1_q;  sc1_d   = sc1_q;
        a2_re_d = a2_re_q;  a2_im_d = a2_im_q;
        sc2_d   = sc2_q;
        if (adv_s) begin
            a1_re_d = a_re;     a1_im_d = a_im;
            b1_re_d = b_re;     b1_im_d = b_im;
            w1_re_d = w_re;     w1_im_d = w_im;
            mode1_d = tw_bypass ? TW_ONE_BYPASS : TW_MULT;
            sc1_d   = scale;
            a2_re_d = a1_re_q;  a2_im_d = a1_im_q;
            sc2_d   = sc1_q;
        end else begin
            a1_re_d = a1_re_q;
            sc2_d   = sc2_q;
        end
    end

    // Datapath registers without reset.
    always_ff @(posedge clock) begin
        a1_re_q <= a1_re_d;  a1_im_q <= a1_im_d;
        b1_re_q <= b1_re_d;  b1_im_q <= b1_im_d;
        w1_re_q <= w1_re_d;  w1_im_q <= w1_im_d;
        mode1_q <= mode1_d;  sc1_q   <= sc1_d;
        a2_re_q <= a2_re_d;  a2_im_q <= a2_im_d;
        sc2_q   <= sc2_d;
    end

    cmul_round #(
        .WIDTH    (WIDTH),
        .TW_WIDTH (TW_WIDTH)
    ) u_cmul (
        .clock (clock),
        .en    (adv_s),
        .b_re  (b1_re_q),
        .b_im  (b1_im_q),
        .w_re  (w1_re_q),
        .w_im  (w1_im_q),
        .mode  (mode1_q),
        .p_re  (p_re_s),
        .p_im  (p_im_s)
    );

    // Butterfly add/subtract, optional halving with round-half-up.
    always_comb begin
        sum_re_s = SW'(a2_re_q) + SW'(p_re_s);
        sum_im_s = SW'(a2_im_q) + SW'(p_im_s);
        dif_re_s = SW'(a2_re_q) - SW'(p_re_s);
        dif_im_s = SW'(a2_im_q) - SW'(p_im_s);
        if (sc2_q) begin
            s_re_s = (sum_re_s + HALF_UP) >>> 1;
            s_im_s = (sum_im_s + HALF_UP) >>> 1;
            t_re_s = (dif_re_s + HALF_UP) >>> 1;
            t_im_s = (dif_im_s + HALF_UP) >>> 1;
        end else begin
            s_re_s = sum_re_s;
            s_im_s = sum_im_s;
            t_re_s = dif_re_s;
            t_im_s = dif_im_s;
        end
    end

    // S3 saturation; ovf is only raised for a real sample, never a bubble.
    always_comb begin
        c_re_d = c_re_q;  c_im_d = c_im_q;
        d_re_d = d_re_q;  d_im_d = d_im_q;
        ovf_d  = ovf_q;
        if (adv_s) begin
            c_re_d = WIDTH'(sat_val(32'(s_re_s), WIDTH));
            c_im_d = WIDTH'(sat_val(32'(s_im_s), WIDTH));
            d_re_d = WIDTH'(sat_val(32'(t_re_s), WIDTH));
            d_im_d = WIDTH'(sat_val(32'(t_im_s), WIDTH));
            ovf_d  = v2_q & (sat_hit(32'(s_re_s), WIDTH) | sat_hit(32'(s_im_s), WIDTH) |
                             sat_hit(32'(t_re_s), WIDTH) | sat_hit(32'(t_im_s), WIDTH));
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Output register with async clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_re_q <= '0;
            c_im_q <= '0;
            d_re_q <= '0;
            d_im_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            c_re_q <= c_re_d;
            c_im_q <= c_im_d;
            d_re_q <= d_re_d;
            d_im_q <= d_im_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = v3_q;
    assign c_re      = c_re_q;
    assign c_im      = c_im_q;
    assign d_re      = d_re_q;
    assign d_im      = d_im_q;
    assign ovf       = ovf_q;

endmodule
